// File: rtl/tx_ilas_gen.sv
// tx_ilas_gen: JESD204B initial lane alignment sequence generator for one lane.
// Emits NUM_MF multiframes of F*K octets with /R/, /A/, /Q/, config and checksum.
module tx_ilas_gen #(
  parameter int F      = 2,
  parameter int K      = 16,
  parameter int NUM_MF = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [103:0] i_cfg,
  output logic [7:0]   o_data,
  output logic         o_vld,
  output logic         o_k,
  output logic         o_busy,
  output logic         o_done
);
  if (F < 1 || F > 256 || K < 1 || K > 32 || F * K < 17 || F * K > 1024 || NUM_MF < 4 || NUM_MF > 8) begin : g_bad_cfg
    $error("tx_ilas_gen: illegal F/K/NUM_MF combination");
  end
  localparam logic [9:0] OCT_LAST = 10'(F * K - 1);
  localparam logic [2:0] MF_LAST  = 3'(NUM_MF - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t       state, nstate;
  logic [9:0]   oct, n_oct;
  logic [2:0]   mf, n_mf;
  logic [127:0] cfg_q;
  logic [7:0]   csum, sum;
  logic [3:0]   cfg_idx;
  logic [7:0]   d_data;
  logic         d_k, emit, fin, last, run, accept;
  always_comb begin
    sum = 8'd0;
    for (int i = 0; i < 13; i++) sum = sum + i_cfg[8*i +: 8];
  end
  // counters track the octet currently on the outputs; n_* is the one being registered
  assign run    = state == RUN;
  assign accept = state == IDLE && i_start && !i_abort;
  assign emit   = !i_abort && (run || accept);
  assign last   = oct == OCT_LAST;
  assign n_oct  = run && !last ? oct + 10'd1 : 10'd0;
  assign n_mf   = !run ? 3'd0 : last ? mf + 3'd1 : mf;
  assign fin    = run && n_mf == MF_LAST && n_oct == OCT_LAST;
  always_comb begin
    nstate = state;
    if (i_abort) nstate = IDLE;
    else if (accept) nstate = RUN;
    else if (fin) nstate = IDLE;
  end
  assign cfg_idx = n_oct[3:0] - 4'd2;
  assign d_k = n_oct == 10'd0 || n_oct == OCT_LAST || (n_mf == 3'd1 && n_oct == 10'd1);
  assign d_data = n_oct == 10'd0 ? 8'h1C :
                  n_oct == OCT_LAST ? 8'h7C :
                  n_mf != 3'd1 ? n_oct[7:0] :
                  n_oct == 10'd1 ? 8'h9C :
                  (n_oct >= 10'd2 && n_oct <= 10'd14) ? cfg_q[{cfg_idx, 3'b000} +: 8] :
                  n_oct == 10'd15 ? csum : n_oct[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oct    <= 10'd0;
      mf     <= 3'd0;
      cfg_q  <= 128'd0;
      csum   <= 8'd0;
      o_data <= 8'd0;
      o_vld  <= 1'b0;
      o_k    <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      if (accept) begin
        cfg_q <= {24'd0, i_cfg};
        csum  <= sum;
      end
      oct    <= emit ? n_oct : 10'd0;
      mf     <= emit ? n_mf : 3'd0;
      o_data <= emit ? d_data : 8'd0;
      o_k    <= emit && d_k;
      o_vld  <= emit;
      o_busy <= emit && !fin;
      o_done <= emit && fin;
    end
  end
endmodule

// File: tb/tb_tx_ilas_gen.sv
// tb_tx_ilas_gen: checks tx_ilas_gen against a positional ILAS model, fixed vectors
// and hand-built back-to-back, restart-ignore, abort and async-reset sequences.
module tb_tx_ilas_gen;
  localparam int F = 2, K = 16, NMF = 4, FK = F * K, LAST = FK * NMF - 1;
  logic         clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_abort = 1'b0;
  logic [103:0] i_cfg = '0;
  logic [7:0]   o_data;
  logic         o_vld, o_k, o_busy, o_done;
  int           n_cmp = 0, n_bad = 0;
  logic [7:0]   cap_d [FK*NMF];
  logic         cap_k [FK*NMF];
  typedef struct { int pos; logic [7:0] d; logic k; } vec_t;
  vec_t tbl [15];

  tx_ilas_gen #(.F(F), .K(K), .NUM_MF(NMF)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_cfg(i_cfg),
    .o_data(o_data), .o_vld(o_vld), .o_k(o_k), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input int p, input logic [103:0] c);
    int o = p % FK, m = p / FK, s = 0;
    if (o == 0) return {1'b1, 8'h1C};
    if (o == FK - 1) return {1'b1, 8'h7C};
    if (m == 1 && o == 1) return {1'b1, 8'h9C};
    if (m == 1 && o >= 2 && o <= 14) return {1'b0, c[8*(o-2) +: 8]};
    if (m == 1 && o == 15) begin
      for (int i = 0; i < 13; i++) s += int'(c[8*i +: 8]);
      return {1'b0, 8'(s % 256)};
    end
    return {1'b0, 8'(o % 256)};
  endfunction

  function automatic logic [103:0] rnd_cfg();
    logic [103:0] c;
    for (int i = 0; i < 13; i++) c[8*i +: 8] = 8'($urandom);
    return c;
  endfunction

  task automatic idle_chk(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, {19'd0, o_vld, o_k, o_busy, o_done, o_data}, 32'd0);
    end
  endtask

  // mode: 0 plain, 1 back-to-back restart at end, 4 start+cfg change mid-run, 5 abort, 6 reset
  task automatic seq(input logic [103:0] c, input int mode, input logic [103:0] c2);
    logic [8:0] e;
    for (int p = 0; p <= LAST; p++) begin
      @(negedge clk);
      i_start = 1'b0;
      e = model(p, c);
      chk($sformatf("oct%0d", p), {19'd0, o_vld, o_k, o_busy, o_done, o_data},
          {19'd0, 1'b1, e[8], p != LAST, p == LAST, e[7:0]});
      cap_d[p] = o_data;
      cap_k[p] = o_k;
      if (mode == 4 && p == 10) i_start = 1'b1;
      if (mode == 4 && p == 20) i_cfg = c2;
      if (mode == 5 && p == 40) begin i_abort = 1'b1; return; end
      if (mode == 6 && p == 70) begin rst_n = 1'b0; return; end
      if (mode == 1 && p == LAST) begin i_start = 1'b1; i_cfg = c2; end
    end
  endtask

  task automatic go(input logic [103:0] c);
    @(negedge clk);
    i_start = 1'b1;
    i_cfg = c;
  endtask

  initial begin
    logic [103:0] c0, c1, c2;
    tbl[0]  = '{0,   8'h1C, 1'b1};
    tbl[1]  = '{32,  8'h1C, 1'b1};
    tbl[2]  = '{64,  8'h1C, 1'b1};
    tbl[3]  = '{96,  8'h1C, 1'b1};
    tbl[4]  = '{31,  8'h7C, 1'b1};
    tbl[5]  = '{63,  8'h7C, 1'b1};
    tbl[6]  = '{95,  8'h7C, 1'b1};
    tbl[7]  = '{127, 8'h7C, 1'b1};
    tbl[8]  = '{33,  8'h9C, 1'b1};
    tbl[9]  = '{34,  8'h01, 1'b0};
    tbl[10] = '{40,  8'h07, 1'b0};
    tbl[11] = '{46,  8'h0D, 1'b0};
    tbl[12] = '{47,  8'h5B, 1'b0};
    tbl[13] = '{5,   8'h05, 1'b0};
    tbl[14] = '{1,   8'h01, 1'b0};
    for (int i = 0; i < 13; i++) c0[8*i +: 8] = 8'(i + 1);
    #1;
    chk("reset", {19'd0, o_vld, o_k, o_busy, o_done, o_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_chk("idle", 50);
    // known config with back-to-back restart into a random config
    c1 = rnd_cfg();
    go(c0);
    seq(c0, 1, c1);
    for (int i = 0; i < 15; i++)
      chk($sformatf("tbl%0d", tbl[i].pos), {23'd0, cap_k[tbl[i].pos], cap_d[tbl[i].pos]}, {23'd0, tbl[i].k, tbl[i].d});
    seq(c1, 0, '0);
    idle_chk("after_b2b", 3);
    // start ignored during run, cfg change ignored
    c1 = rnd_cfg();
    c2 = rnd_cfg();
    go(c1);
    seq(c1, 4, c2);
    idle_chk("after_ignore", 3);
    // abort mid-sequence
    go(c1);
    seq(c1, 5, '0);
    @(negedge clk);
    chk("abort", {19'd0, o_vld, o_k, o_busy, o_done, o_data}, 32'd0);
    i_abort = 1'b0;
    idle_chk("post_abort", 5);
    // start and abort together: abort wins
    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    idle_chk("start_abort", 4);
    c2 = rnd_cfg();
    go(c2);
    seq(c2, 0, '0);
    // async reset mid-sequence
    go(c2);
    seq(c2, 6, '0);
    #1;
    chk("async_rst", {19'd0, o_vld, o_k, o_busy, o_done, o_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_chk("post_rst", 10);
    // randomized sequences with random idle gaps
    for (int r = 0; r < 4; r++) begin
      c1 = rnd_cfg();
      idle_chk("gap", int'($urandom_range(1, 6)));
      go(c1);
      seq(c1, 0, '0);
    end
    idle_chk("final_idle", 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
